// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// Holds the FSM state encodings and the default data word width.
// Imported by piso_bit_cnt and piso_shift_tx.
package piso_pkg;

    // Default width of the parallel word.
    localparam int PISO_DEF_WIDTH = 4;

    // ST_PAR is reachable only when PISO_SHIFT_TX_PARITY_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } piso_state_e;

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter for the serialiser: counts 0..WIDTH-1 and then holds at WIDTH-1.
// Latency: the count changes one clk after clr/inc; last is decoded from the register.
// Backpressure: none. The counter follows clr/inc every cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset (count <= 0)
//   clr  - load zero (takes priority over inc)
//   inc  - advance by one, saturating at WIDTH-1
//   last - high while count == WIDTH-1
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;

    // Saturate at the last position so that the count never wraps while
    // the FSM sits in the parity cycle or idles after a word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != LAST_VAL)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign last = (r_cnt == LAST_VAL);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and sends it one bit per clk.
// Latency: a word accepted at edge k puts its first bit on sout in cycle k+1 and occupies WIDTH (+1 parity) cycles.
// Backpressure: din_ready is high only when idle or in the final bit cycle, which allows gapless back-to-back words.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous, active-high reset; the partial word is dropped
//   din       - parallel word, captured when din_valid && din_ready
//   din_valid - din holds a word to send
//   din_ready - a word will be accepted at this edge
//   sout      - serial data bit (0 outside a frame)
//   sframe    - high while sout carries a word bit or the parity bit
//   done      - high during the final bit cycle of a word
// Build option: define PISO_SHIFT_TX_PARITY_EN to append an even-parity bit to each word.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sframe,
    output logic             done
);

    piso_state_e      r_state;
    piso_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic             w_last;
    logic             w_xfer;
    logic             w_cnt_inc;
`ifdef PISO_SHIFT_TX_PARITY_EN
    logic             r_par;
`endif

    // din_ready depends only on registered state, so this has no loop.
    assign w_xfer = din_valid && din_ready;

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_xfer),
        .inc  (w_cnt_inc),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        din_ready   = 1'b0;
        sframe      = 1'b0;
        sout        = 1'b0;
        done        = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sframe    = 1'b1;
                sout      = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
                w_cnt_inc = 1'b1;
`ifdef PISO_SHIFT_TX_PARITY_EN
                // The word ends on the parity cycle, so no handshake here.
                if (w_last) begin
                    w_state_nxt = ST_PAR;
                end
`else
                // Accepting on the last bit reloads without an idle gap.
                if (w_last) begin
                    done        = 1'b1;
                    din_ready   = 1'b1;
                    w_state_nxt = din_valid ? ST_SHIFT : ST_IDLE;
                end
`endif
            end
`ifdef PISO_SHIFT_TX_PARITY_EN
            ST_PAR: begin
                sframe      = 1'b1;
                sout        = r_par;
                done        = 1'b1;
                din_ready   = 1'b1;
                w_state_nxt = din_valid ? ST_SHIFT : ST_IDLE;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift toward the output end with zero fill; after WIDTH shifts the
    // register is all zero, so an idle shreg never leaks stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (w_xfer) begin
            r_shreg <= din;
        end else if (r_state == ST_SHIFT) begin
            if (MSB_FIRST) begin
                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            end else begin
                r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
            end
        end
    end

`ifdef PISO_SHIFT_TX_PARITY_EN
    // Parity is taken from the captured word because shreg is consumed by shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_xfer) begin
            r_par <= ^din;
        end
    end
`endif

endmodule

// File: tb/tb_piso_shift_tx.sv
// Testbench for piso_shift_tx at WIDTH=4, with one MSB-first and one LSB-first instance driven in parallel.
// Each accepted word pushes its expected {done, sout} sequence into a per-instance queue.
// Every cycle the queue head is compared against the instance outputs.
module tb_piso_shift_tx;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready_m, sout_m, sframe_m, done_m;
    logic         din_ready_l, sout_l, sframe_l, done_l;

    int n_vec;
    int n_err;

    // Each entry is {done, sout} for one frame cycle.
    logic [1:0] q_m[$];
    logic [1:0] q_l[$];

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready_m),
        .sout      (sout_m),
        .sframe    (sframe_m),
        .done      (done_m)
    );

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready_l),
        .sout      (sout_l),
        .sframe    (sframe_l),
        .done      (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        logic [1:0] e;
        for (int i = 0; i < W; i++) begin
`ifdef PISO_SHIFT_TX_PARITY_EN
            e[1] = 1'b0;
`else
            e[1] = (i == W - 1);
`endif
            e[0] = w[W-1-i];
            q_m.push_back(e);
            e[0] = w[i];
            q_l.push_back(e);
        end
`ifdef PISO_SHIFT_TX_PARITY_EN
        e = {1'b1, ^w};
        q_m.push_back(e);
        q_l.push_back(e);
`endif
    endtask

    // Called just after a falling edge with the inputs already driven:
    // check this cycle's outputs, advance through the rising edge, then
    // return at the next falling edge.
    task automatic step();
        logic [1:0] em, el;
        logic       rm, rl, xfer;
        em = (q_m.size() > 0) ? q_m[0] : 2'b00;
        el = (q_l.size() > 0) ? q_l[0] : 2'b00;
        rm = (q_m.size() <= 1);
        rl = (q_l.size() <= 1);
        chk_eq("msb_sframe", sframe_m, q_m.size() > 0);
        chk_eq("msb_sout",   sout_m,   em[0]);
        chk_eq("msb_done",   done_m,   em[1]);
        chk_eq("msb_ready",  din_ready_m, rm);
        chk_eq("lsb_sframe", sframe_l, q_l.size() > 0);
        chk_eq("lsb_sout",   sout_l,   el[0]);
        chk_eq("lsb_done",   done_l,   el[1]);
        chk_eq("lsb_ready",  din_ready_l, rl);
        xfer = din_valid && rm && !rst;
        @(posedge clk);
        if (rst) begin
            q_m.delete();
            q_l.delete();
        end else begin
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
            if (xfer) push_word(din);
        end
        @(negedge clk);
    endtask

    // Hold din_valid until the bench model expects acceptance, then step
    // through the accepting edge.
    task automatic send(input logic [W-1:0] w);
        int guard;
        din       = w;
        din_valid = 1'b1;
        guard     = 0;
        while ((q_m.size() > 1) && (guard < 20)) begin
            step();
            guard++;
        end
        if (guard >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: word %0h not accepted within 20 cycles", w);
        end
        step();
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset state: idle outputs with ready high.
        step();
        rst = 1'b0;
        idle(2);

        // Single word, both bit orders.
        send(4'b1011);
        idle(6);

        // Back-to-back words with din_valid held.
        send(4'b1011);
        send(4'b0110);
        idle(7);

        // A word offered while busy must not be accepted.
        send(4'b1011);
        din       = 4'b1111;
        din_valid = 1'b1;
        step();
        step();
        din_valid = 1'b0;
        idle(6);

        // Reset after two bits drops the rest of the word.
        send(4'b1011);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(3);

        // Reset and a valid word at the same edge: reset wins.
        din       = 4'b1011;
        din_valid = 1'b1;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        din_valid = 1'b0;
        idle(6);

        // Parity corner words, then random traffic with random gaps.
        send(4'b0110);
        idle(2);
        send(4'b0000);
        send(4'b1111);
        idle(6);
        for (int k = 0; k < 30; k++) begin
            send(W'($urandom_range(0, (1 << W) - 1)));
            idle($urandom_range(0, 2));
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
